// File: rtl/softmax_pkg.sv
// Shared softmax definitions: default widths and output-writer FSM encoding.
package softmax_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int NUM_DEF       = 2;
  localparam int ADDRSIZE_DEF  = 8;
  localparam int WORD_W_DEF    = DATAWIDTH_DEF * NUM_DEF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } wr_state_e;

endpackage

// File: rtl/softmax_out_fifo.sv
// Small synchronous staging FIFO with flush; head word is read straight from storage.
module softmax_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/softmax_out_writer.sv
// Packs softmax lane pairs into words and writes them to output memory from a base address.
// Optional checksum output enabled by defining SOFTMAX_OUT_CSUM_EN.
module softmax_out_writer
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int NUM        = NUM_DEF,
  parameter int ADDRSIZE   = ADDRSIZE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [ADDRSIZE-1:0]       base_addr,
  input  logic [ADDRSIZE-1:0]       frame_len,
  input  logic                      in_valid,
  input  logic [DATAWIDTH-1:0]      in_data0,
  input  logic [DATAWIDTH-1:0]      in_data1,
  output logic                      mem_wr_en,
  output logic [ADDRSIZE-1:0]       mem_wr_addr,
  output logic [DATAWIDTH*NUM-1:0]  mem_wr_data,
  input  logic                      mem_wr_ready,
  output logic                      busy,
  output logic                      wr_done,
`ifdef SOFTMAX_OUT_CSUM_EN
  output logic [DATAWIDTH*NUM-1:0]  csum,
`endif
  output logic                      overflow
);
  localparam int WORD_W = DATAWIDTH * NUM;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  wr_state_e             state_q, state_d;
  logic [ADDRSIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDRSIZE-1:0]   remaining_q, remaining_d;
  logic [ADDRSIZE-1:0]   in_cnt_q, in_cnt_d;
  logic [ADDRSIZE-1:0]   len_q, len_d;
  logic                  overflow_q, overflow_d;

  logic                  hs, in_window, all_in, beat_ok, fin;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [WORD_W-1:0]     fifo_head, in_word;

  assign in_word = {in_data1, in_data0};

  softmax_out_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (init),
    .push  (beat_ok),
    .din   (in_word),
    .pop   (hs),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mem_wr_en   = !fifo_empty;
  assign mem_wr_addr = wr_ptr_q;
  assign mem_wr_data = fifo_empty ? '0 : fifo_head;
  assign hs          = mem_wr_en && mem_wr_ready;
  assign busy        = (state_q == S_ARMED) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wr_done     = (state_q == S_DONE);
  assign overflow    = overflow_q;

  always_comb begin
    in_window   = (state_q == S_ARMED) || (state_q == S_RUN);
    all_in      = (in_cnt_q == len_q);
    beat_ok     = in_valid && in_window && !all_in && !init;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    in_cnt_d    = in_cnt_q;
    len_d       = len_q;
    overflow_d  = overflow_q;
    if (init) begin
      wr_ptr_d    = base_addr;
      remaining_d = frame_len;
      in_cnt_d    = '0;
      len_d       = frame_len;
      overflow_d  = 1'b0;
    end else begin
      if (hs) begin
        wr_ptr_d    = wr_ptr_q + ADDRSIZE'(1);
        remaining_d = remaining_q - ADDRSIZE'(1);
      end
      if (beat_ok) in_cnt_d = in_cnt_q + ADDRSIZE'(1);
      if (beat_ok && fifo_full && !hs) overflow_d = 1'b1;
    end
    // after an overflow the dropped beats never reach memory, so remaining may stay nonzero
    fin = (fifo_empty || (fifo_count == CW'(1) && hs)) &&
          ((remaining_d == '0) || overflow_q);
  end

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = S_ARMED;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ARMED: if (in_valid) state_d = S_RUN;
        S_RUN:   if (all_in) state_d = fin ? S_DONE : S_DRAIN;
        S_DRAIN: if (fin) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      in_cnt_q    <= '0;
      len_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      in_cnt_q    <= in_cnt_d;
      len_q       <= len_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef SOFTMAX_OUT_CSUM_EN
  logic [WORD_W-1:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     csum_q <= '0;
    else if (init) csum_q <= '0;
    else if (hs)   csum_q <= csum_q ^ mem_wr_data;
  end

  assign csum = csum_q;
`endif

endmodule
